// File: rtl/drbg_line_key_scheduler_if.sv
// DRBG request/ready handshake bundle between the line key scheduler (master) and the hash DRBG (slave).
interface drbg_line_key_scheduler_if #(
  parameter int KEY_WIDTH = 256
);
  logic                 drbg_init;
  logic                 drbg_next_seed;
  logic                 drbg_next_bits;
  logic                 drbg_init_ready;
  logic                 drbg_next_bits_ready;
  logic [KEY_WIDTH-1:0] drbg_random_bits;

  modport master (
    output drbg_init,
    output drbg_next_seed,
    output drbg_next_bits,
    input  drbg_init_ready,
    input  drbg_next_bits_ready,
    input  drbg_random_bits
  );

  modport slave (
    input  drbg_init,
    input  drbg_next_seed,
    input  drbg_next_bits,
    output drbg_init_ready,
    output drbg_next_bits_ready,
    output drbg_random_bits
  );
endinterface

// File: rtl/drbg_line_key_scheduler.sv
// Prefetches one DRBG key per video line and reseeds every FRAMES_PER_RESEED frames; key appears 1 cycle after line_start.
// No backpressure: a line_start with no buffered key pulses key_miss and the pending key serves the next line.
module drbg_line_key_scheduler #(
  parameter int KEY_WIDTH         = 256,
  parameter int FRAMES_PER_RESEED = 8,
  parameter int TIMEOUT_CYCLES    = 4096
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic                          frame_start,
  input  logic                          line_start,
  drbg_line_key_scheduler_if.master     drbg,
  output logic [KEY_WIDTH-1:0]          line_key,
  output logic                          line_key_valid,
  output logic                          key_miss,
  output logic [15:0]                   reseed_count,
  output logic                          error
);

  localparam int FC_W = (FRAMES_PER_RESEED > 1) ? $clog2(FRAMES_PER_RESEED) : 1;
  localparam int WC_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_RESEED - 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT_REQ,
    ST_GAP,
    ST_FETCH,
    ST_HOLD,
    ST_RESEED_REQ,
    ST_RESEED_WAIT,
    ST_ERROR
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic                 init_rdy_q;
  logic                 bits_rdy_q;
  logic                 init_edge;
  logic                 bits_edge;
  logic [WC_W-1:0]      wait_cnt;
  logic                 waiting;
  logic                 wait_expired;
  logic [FC_W-1:0]      frame_cnt;
  logic                 frame_wrap;
  logic                 reseed_pending;
  logic                 buf_full;
  logic                 key_load;
  logic [KEY_WIDTH-1:0] key_buf;

  // A ready level held high must not count twice, so only rising edges advance the FSM.
  assign init_edge    = drbg.drbg_init_ready & ~init_rdy_q;
  assign bits_edge    = drbg.drbg_next_bits_ready & ~bits_rdy_q;
  assign waiting      = (state == ST_INIT_REQ) || (state == ST_FETCH) || (state == ST_RESEED_WAIT);
  assign wait_expired = (wait_cnt == WC_LAST);
  assign frame_wrap   = frame_start && (frame_cnt == FC_LAST);
  assign key_load     = enable && (state == ST_FETCH) && bits_edge;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:        state_nxt = ST_INIT_REQ;
        ST_INIT_REQ: begin
          if (init_edge)         state_nxt = ST_GAP;
          else if (wait_expired) state_nxt = ST_ERROR;
        end
        ST_GAP:         state_nxt = reseed_pending ? ST_RESEED_REQ : ST_FETCH;
        ST_FETCH: begin
          if (bits_edge)         state_nxt = ST_HOLD;
          else if (wait_expired) state_nxt = ST_ERROR;
        end
        ST_HOLD: begin
          if (line_start)        state_nxt = ST_GAP;
        end
        ST_RESEED_REQ:  state_nxt = ST_RESEED_WAIT;
        ST_RESEED_WAIT: begin
          if (init_edge)         state_nxt = ST_GAP;
          else if (wait_expired) state_nxt = ST_ERROR;
        end
        ST_ERROR:       state_nxt = ST_ERROR;
        default:        state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    drbg.drbg_init      = 1'b0;
    drbg.drbg_next_seed = 1'b0;
    drbg.drbg_next_bits = 1'b0;
    error               = 1'b0;
    case (state)
      ST_INIT_REQ:   drbg.drbg_init      = 1'b1;
      ST_FETCH:      drbg.drbg_next_bits = 1'b1;
      ST_RESEED_REQ: drbg.drbg_next_seed = 1'b1;
      ST_ERROR:      error               = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (key_load) begin
      key_buf <= drbg.drbg_random_bits;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      init_rdy_q     <= 1'b0;
      bits_rdy_q     <= 1'b0;
      wait_cnt       <= '0;
      frame_cnt      <= '0;
      reseed_pending <= 1'b0;
      reseed_count   <= '0;
      buf_full       <= 1'b0;
      line_key       <= '0;
      line_key_valid <= 1'b0;
      key_miss       <= 1'b0;
    end else begin
      init_rdy_q <= drbg.drbg_init_ready;
      bits_rdy_q <= drbg.drbg_next_bits_ready;
      key_miss   <= 1'b0;

      if ((state_nxt != state) || !waiting) begin
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + WC_W'(1);
      end

      if (!enable) begin
        frame_cnt      <= '0;
        reseed_pending <= 1'b0;
        buf_full       <= 1'b0;
        line_key_valid <= 1'b0;
      end else begin
        // Completion is handled before the frame counter so a new wrap in the same cycle keeps the request.
        if ((state == ST_RESEED_WAIT) && init_edge) begin
          reseed_count   <= reseed_count + 16'd1;
          reseed_pending <= 1'b0;
        end
        if (frame_start) begin
          if (frame_wrap) begin
            frame_cnt      <= '0;
            reseed_pending <= 1'b1;
          end else begin
            frame_cnt <= frame_cnt + FC_W'(1);
          end
        end

        if (key_load) begin
          buf_full <= 1'b1;
        end
        if (line_start) begin
          if (buf_full) begin
            line_key       <= key_buf;
            line_key_valid <= 1'b1;
            buf_full       <= 1'b0;
          end else begin
            key_miss       <= 1'b1;
            line_key_valid <= 1'b0;
          end
        end
        if (state_nxt == ST_ERROR) begin
          line_key_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/drbg_line_key_scheduler.md
# drbg_line_key_scheduler

Sequences the `master_hash_slave_hash_drbg` for the scrambler datapath. It initializes the DRBG, prefetches one 256-bit key per video line, and presents that key to the line scrambler on each `line_start`. It also issues a reseed every `FRAMES_PER_RESEED` frames. It sits between the TVP5147M1 decoder timing (frame/line strobes) and the DRBG, and owns the DRBG `init`/`next_seed`/`next_bits` handshakes.

## Interface
Parameters:
- `KEY_WIDTH`, 256, width of the DRBG output and of the line key.
- `FRAMES_PER_RESEED`, 8, number of `frame_start` pulses between reseeds (≥1).
- `TIMEOUT_CYCLES`, 4096, maximum number of cycles to wait for any DRBG ready before entering ERROR.

Ports:
- `clk`  in  1  single clock. Reset is synchronous and active-low.
- `reset_n`  in  1  synchronous active-low reset.
- `enable`  in  1  level; low forces IDLE.
- `frame_start`  in  1  one-cycle pulse at frame start.
- `line_start`  in  1  one-cycle pulse at active-line start.
- `drbg_init`  out  1  to DRBG `init` (level).
- `drbg_next_seed`  out  1  to DRBG `next_seed` (one-cycle pulse).
- `drbg_next_bits`  out  1  to DRBG `next_bits` (level).
- `drbg_init_ready`  in  1  from DRBG `init_ready`.
- `drbg_next_bits_ready`  in  1  from DRBG `next_bits_ready`.
- `drbg_random_bits`  in  KEY_WIDTH  from DRBG `random_bits`.
- `line_key`  out  KEY_WIDTH  key for the current line.
- `line_key_valid`  out  1  level; `line_key` is usable for the current line.
- `key_miss`  out  1  one-cycle pulse when `line_start` arrives with no buffered key.
- `reseed_count`  out  16  number of completed reseeds; wraps at 2^16.
- `error`  out  1  sticky; a DRBG handshake timed out.

## Operation
- **Ready detection:** both DRBG ready inputs are registered. A "ready edge" is the input high with its registered copy low. A level that stays high is never re-counted.
- **FSM states:** IDLE, INIT_REQ, GAP, FETCH, HOLD, RESEED_REQ, RESEED_WAIT, ERROR.
- **IDLE:** all DRBG outputs are 0. If `enable` is high, go to INIT_REQ.
- **INIT_REQ:** `drbg_init`=1 until the `drbg_init_ready` edge, then `drbg_init`=0 and go to GAP.
- **GAP:** exactly one cycle with all DRBG requests low. Exit to RESEED_REQ if `reseed_pending` is set, otherwise to FETCH.
- **FETCH:** `drbg_next_bits`=1 until the `drbg_next_bits_ready` edge. In that cycle, capture `drbg_random_bits` into the prefetch buffer, set `buf_full`=1, drop `drbg_next_bits`, and go to HOLD.
- **HOLD:** wait for `line_start`. On `line_start`, copy the buffer to `line_key`, set `line_key_valid`=1, set `buf_full`=0, and go to GAP.
- **RESEED_REQ:** `drbg_next_seed`=1 for one cycle, then go to RESEED_WAIT.
- **RESEED_WAIT:** wait for the `drbg_init_ready` edge. Then clear `reseed_pending`, increment `reseed_count`, and go to GAP.
- **Key miss:** `line_start` while `buf_full`=0 (any non-HOLD state) pulses `key_miss` and sets `line_key_valid`=0. The key being fetched is buffered and used at the next `line_start`. A key is never used twice or skipped.
- **Frame counting:** each `frame_start` increments `frame_cnt`. When `frame_cnt` reaches `FRAMES_PER_RESEED`-1, reset it to 0 and set `reseed_pending`. A reseed never interrupts FETCH; it runs at the next GAP.
- **Simultaneous `frame_start` and `line_start`:** both are processed in the same cycle. The line consumes the buffered key, and the reseed runs before the next fetch.
- **Timeout:** a wait counter clears on every state change. If it reaches `TIMEOUT_CYCLES` in INIT_REQ, FETCH or RESEED_WAIT, go to ERROR.
- **ERROR:** `error`=1, all DRBG requests are 0, `line_key_valid`=0. Leave only via reset or `enable`=0, which goes to IDLE and clears `error`.
- **`enable` low in any state:** next cycle is IDLE. `buf_full`, `reseed_pending`, `frame_cnt` and `line_key_valid` are cleared. `line_key` keeps its value. `reseed_count` keeps its value.

## Timing
- **Reset values:** all outputs 0, `line_key`=0, FSM in IDLE, `buf_full`=0, `frame_cnt`=0, wait counter 0.
- **Enable to init:** `enable` rising in IDLE gives `drbg_init`=1 on the next cycle.
- **Init release:** `drbg_init` falls the cycle after the `drbg_init_ready` edge is sampled.
- **Key capture:** the buffer is loaded on the clock edge where the `next_bits_ready` edge is detected. `drbg_next_bits` is low in the following cycle.
- **Line key presentation:** `line_key` and `line_key_valid` update one cycle after the `line_start` pulse. `line_key_valid` then stays at that value until the next `line_start`.
- **Minimum spacing:** two `line_start` pulses need at least (DRBG latency + 3) cycles apart to avoid a miss.
- **Key miss pulse:** `key_miss` is high for exactly the cycle after the offending `line_start`.

## Test plan
- **Bring-up and first line:** reset, `enable`=1, model DRBG ready 10 cycles after request, `random_bits`=0xAA..AA. Then `line_start` → `drbg_init` high for 11 cycles, one GAP cycle, `drbg_next_bits` for 11 cycles, `line_key`=0xAA..AA and `line_key_valid`=1 one cycle after `line_start`.
- **Steady stream:** 20 `line_start` pulses 50 cycles apart, DRBG returning incrementing values 1..20 → `line_key` sequence is 1..20 with no `key_miss`.
- **Miss:** DRBG latency 100, `line_start` every 40 cycles → `key_miss` pulses and `line_key_valid`=0 on the affected lines. Each key value is still presented exactly once, in order.
- **Reseed cadence:** `FRAMES_PER_RESEED`=2, 5 `frame_start` pulses, one of them coincident with `line_start` → exactly 2 `drbg_next_seed` pulses, each in a GAP and never during FETCH. `reseed_count`=2.
- **Timeout:** DRBG never asserts `next_bits_ready`, `TIMEOUT_CYCLES`=64 → `error`=1 after 64 FETCH cycles with `drbg_next_bits`=0. Then `enable`=0 → IDLE with `error`=0.
- **Mid-operation reset:** assert `reset_n`=0 during FETCH → next cycle all outputs 0 and state IDLE. The reset is synchronous, so no change occurs before the clock edge.
